// File: rtl/arb_pkg.sv
// Shared types and sizes for the 8-way round-robin arbiter.
// Imported by rr_pick and rr_arbiter8.
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {IDLE, GRANT} arb_state_t;
    typedef logic [IDX_W-1:0] arb_idx_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: finds the first set bit of (req & ~mask),
// searching start, start+1, ... and wrapping modulo N_REQ.
module rr_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] mask,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [N_REQ-1:0] eff;
    arb_idx_t         cand;

    assign eff = req & ~mask;

    always_comb begin
        found = 1'b0;
        idx   = start;
        cand  = start;
        for (int i = 0; i < N_REQ; i++) begin
            // 3-bit addition wraps naturally from 7 back to 0
            cand = start + IDX_W'(i);
            if (!found && eff[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters; grant held until done.
// Optional forced release after TIMEOUT cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter8
    import arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
    parameter int TIMEOUT = 64
)
`endif
(
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    arb_state_t       state, state_n;
    arb_idx_t         ptr, ptr_n;
    arb_idx_t         gnt_idx_n;
    logic [N_REQ-1:0] pick_mask;
    arb_idx_t         pick_start;
    logic             pick_found;
    arb_idx_t         pick_idx;
    logic             tmo_hit;
    logic             rel;

    // IDLE searches from ptr; a release searches past the owner with it masked
    always_comb begin
        pick_start = ptr;
        pick_mask  = '0;
        if (state == GRANT) begin
            pick_start = gnt_idx + 3'd1;
            pick_mask  = N_REQ'(1) << gnt_idx;
        end
    end

    rr_pick u_pick (
        .req   (req),
        .mask  (pick_mask),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign rel = (state == GRANT) && (done || tmo_hit);

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        gnt_idx_n = gnt_idx;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    gnt_idx_n = pick_idx;
                    state_n   = GRANT;
                end
            end
            GRANT: begin
                if (rel) begin
                    ptr_n = gnt_idx + 3'd1;
                    if (pick_found) begin
                        gnt_idx_n = pick_idx;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= '0;
            gnt_idx <= '0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            gnt_idx <= gnt_idx_n;
        end
    end

    assign gnt_valid = (state == GRANT);

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [CNT_W-1:0] hold_cnt;
    logic             new_grant;

    assign new_grant = (state_n == GRANT) && ((state == IDLE) || rel);
    assign tmo_hit   = (state == GRANT) && (hold_cnt == CNT_W'(TIMEOUT - 1));
    assign timeout   = tmo_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt <= '0;
        end else if (new_grant) begin
            hold_cnt <= '0;
        end else if (state == GRANT) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign timeout = 1'b0;
`endif

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- 8-requester round-robin arbiter that produces the 3-bit select index for the 3-to-8 decoder stage directly downstream.
- The decoder turns gnt_idx into a one-hot enable; this block decides who owns the shared resource and for how long.
- A grant is held until the owner signals done, then ownership rotates fairly.

Parameters:
- N_REQ, 8, number of requesters (fixed at 8 for this instance; the decoder width matches it)
- IDX_W, 3, index width, equals clog2(N_REQ)
- TIMEOUT, 64, max cycles a grant may be held (used only with ARB_TIMEOUT_EN)

Ports:
- clk  in  1  rising-edge clock, the only clock
- reset  in  1  synchronous, active-high reset
- req  in  8  request vector, bit i = requester i wants the resource
- done  in  1  current owner releases the grant; valid only while gnt_valid=1
- gnt_idx  out  3  index of the current owner; feeds the decoder select input
- gnt_valid  out  1  gnt_idx is meaningful; the downstream decoder output is gated with this
- timeout  out  1  one-cycle pulse on forced release (constant 0 without ARB_TIMEOUT_EN)

Behaviour:
- Reset state: state=IDLE, gnt_valid=0, gnt_idx=0, ptr=0, timeout=0, hold counter=0. Reset overrides every other event in the same cycle, including an active grant.
- Priority pointer ptr (3 bits): the winner is the first set req bit searching ptr, ptr+1, ... 7, 0, ... ptr-1. Search wraps modulo 8.
- FSM state IDLE:
  - If req != 0 at edge t, register the winner into gnt_idx, set gnt_valid=1 from cycle t+1, and go to GRANT.
  - Arbitration latency is 1 cycle.
  - If req == 0, stay in IDLE with gnt_valid=0. gnt_idx holds its last value.
- FSM state GRANT:
  - gnt_idx and gnt_valid are stable until release.
  - Deasserting req[gnt_idx] does not end the grant; only done does.
  - Changes on other req bits are ignored while in GRANT.
- Release on done=1 in GRANT:
  - ptr <= gnt_idx+1, wrapping 7 to 0.
  - The new winner is searched from gnt_idx+1 using the current req vector, with the releasing bit masked out for this one cycle.
  - If a winner exists: gnt_idx <= winner, gnt_valid stays 1, stay in GRANT. This is a zero-bubble back-to-back grant.
  - If no winner: gnt_valid <= 0, go to IDLE.
- done while gnt_valid=0 is ignored.
- A lone requester that holds req through its release is re-granted on the next arbitration, with one IDLE cycle between grants.
- Fairness: with all 8 requesting continuously, grants cycle 0,1,2,...,7,0 with no requester skipped.

Optional Feature:
- Macro: ARB_TIMEOUT_EN
- When defined:
  - A hold counter counts cycles in GRANT and resets on each new grant.
  - If done has not arrived when the counter reaches TIMEOUT-1, the block performs a release exactly as if done=1 and pulses timeout=1 for that cycle.
  - done and timeout in the same cycle count as one release.
- When undefined: no counter is built, timeout is tied to 0, and a grant may be held indefinitely.

Decomposition:
- Package arb_pkg holds:
  - N_REQ and IDX_W localparams
  - typedef enum logic {IDLE, GRANT} arb_state_t
  - typedef logic [IDX_W-1:0] arb_idx_t
- Sub-module rr_pick: purely combinational rotate-and-priority-encode.
  - Inputs: req[7:0], mask[7:0], start[2:0].
  - Outputs: found, idx[2:0].
  - Instantiated once; used for both IDLE arbitration and the back-to-back case.

Test Plan:
- Reset then req=8'b0000_0100 -> one cycle later gnt_valid=1, gnt_idx=2; done pulse with req=0 -> next cycle gnt_valid=0, state IDLE.
- req=8'hFF held and done pulsed every cycle in GRANT -> gnt_idx sequence 0,1,...,7,0 with gnt_valid never dropping.
- Granted to 5 with req=8'b0010_0001 -> done -> gnt_idx=0 next cycle (wrap), not 5 again.
- Granted to 3, req[3] dropped with no done for 20 cycles -> gnt_idx stays 3, gnt_valid stays 1.
- reset asserted during GRANT with done=1 in the same cycle -> next cycle gnt_valid=0, gnt_idx=0, ptr=0.
- With ARB_TIMEOUT_EN and TIMEOUT=4: grant to 1, no done -> timeout pulse in the 4th GRANT cycle and the grant moves to the next requester; without the macro, timeout stays 0 forever.
